// File: rtl/alu_exec_stage_pkg.sv
// rtl/alu_exec_stage_pkg.sv - opcodes and command record shared by the alu and its exec stage
package alu_exec_stage_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic       use_acc;
    logic       wr_acc;
  } cmd_t;

endpackage

// File: rtl/alu_exec_stage_alu.sv
// rtl/alu_exec_stage_alu.sv - 4-bit combinational alu
module alu_exec_stage_alu
  import alu_exec_stage_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [2:0] i_sel,
  output logic [3:0] o_y,
  output logic       o_c_out
);

  logic [4:0] w_sum;
  logic [4:0] w_dif;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  // bit 4 of the difference is the borrow out
  assign w_dif = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_y     = 4'h0;
    o_c_out = 1'b0;
    case (i_sel)
      OP_ADD: begin
        o_y     = w_sum[3:0];
        o_c_out = w_sum[4];
      end
      OP_SUB: begin
        o_y     = w_dif[3:0];
        o_c_out = w_dif[4];
      end
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_NOT:  o_y = ~i_a;
      OP_SHL:  o_y = i_a << i_b[1:0];
      OP_SHR:  o_y = i_a >> i_b[1:0];
      default: o_y = 4'h0;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - two-stage registered wrapper around the alu with accumulator and flags
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int         CNT_W   = 8,
  parameter logic [3:0] ACC_RST = 4'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_use_acc,
  input  logic             in_wr_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_y,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_ovf,
  output logic [3:0]       acc_q,
  output logic [CNT_W-1:0] op_count
);

  logic             r_s1_valid;
  cmd_t             r_s1_cmd;
  logic             r_s2_valid;
  logic [3:0]       r_y;
  logic             r_carry;
  logic             r_zero;
  logic             r_ovf;
  logic [3:0]       r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic       w_s1_adv;
  logic       w_accept;
  logic [3:0] w_a;
  logic [3:0] w_y;
  logic       w_c;
  logic       w_ovf;

  assign w_s1_adv = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready = !r_s1_valid || w_s1_adv;
  assign w_accept = in_valid && in_ready;
  // acc is written on the edge an op leaves stage 1, so the next op always sees it
  assign w_a      = r_s1_cmd.use_acc ? r_acc : r_s1_cmd.a;

  alu_exec_stage_alu alu_inst (
    .i_a     (w_a),
    .i_b     (r_s1_cmd.b),
    .i_sel   (r_s1_cmd.sel),
    .o_y     (w_y),
    .o_c_out (w_c)
  );

  always_comb begin
    w_ovf = 1'b0;
    case (r_s1_cmd.sel)
      OP_ADD:  w_ovf = (w_a[3] == r_s1_cmd.b[3]) && (w_y[3] != w_a[3]);
      OP_SUB:  w_ovf = (w_a[3] != r_s1_cmd.b[3]) && (w_y[3] != w_a[3]);
      default: w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_cmd   <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_cmd   <= '{sel: in_sel, a: in_a, b: in_b, use_acc: in_use_acc, wr_acc: in_wr_acc};
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_y        <= 4'h0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_y        <= w_y;
      r_carry    <= w_c;
      r_zero     <= (w_y == 4'h0);
      r_ovf      <= w_ovf;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= ACC_RST;
    end else if (acc_clr) begin
      r_acc <= ACC_RST;
    end else if (w_s1_adv && r_s1_cmd.wr_acc) begin
      r_acc <= w_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_s2_valid && out_ready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_y     = r_y;
  assign out_carry = r_carry;
  assign out_zero  = r_zero;
  assign out_ovf   = r_ovf;
  assign acc_q     = r_acc;
  assign op_count  = r_cnt;

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Registered execution wrapper around the existing 4-bit combinational alu. It accepts operation commands over a valid/ready handshake, optionally substitutes an internal accumulator for operand A, and drives the alu. It captures y/c_out plus derived flags into an output register with its own valid/ready handshake. It is the sequential stage that feeds the alu and consumes its result. The pipeline is two stages, sustains one op per cycle and stalls cleanly under backpressure.

Parameters:
CNT_W, 8, width of completed-operation counter (wraps)
ACC_RST, 4'h0, accumulator value after reset or clear

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  command valid
in_ready  out  1  stage can accept command this cycle
in_sel  in  3  alu opcode (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 shl, 111 shr)
in_a  in  4  operand A (ignored when in_use_acc=1)
in_b  in  4  operand B (B[1:0] = shift amount for shifts)
in_use_acc  in  1  use accumulator as operand A
in_wr_acc  in  1  write result into accumulator on completion
acc_clr  in  1  synchronous accumulator clear
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_y  out  4  result
out_carry  out  1  alu c_out (carry for add, borrow for sub, 0 otherwise)
out_zero  out  1  out_y == 0
out_ovf  out  1  signed overflow (add/sub only, else 0)
acc_q  out  4  current accumulator value
op_count  out  CNT_W  results handed downstream (wraps)

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_y=0, all flags 0, acc_q=ACC_RST, op_count=0. On rst_n=0 mid-operation, all in-flight ops are discarded. No result appears after release.
- Stage 1 (command reg): captures sel, a, b, use_acc and wr_acc when in_valid && in_ready.
- alu inputs come combinationally from stage 1: A = use_acc ? acc_q : s1_a, B = s1_b, sel = s1_sel.
- s1_adv = s1_valid && (!s2_valid || out_ready).
- in_ready = !s1_valid || s1_adv. This is a combinational path from out_ready, and it allows full throughput.
- Stage 2 (result reg): on s1_adv, load out_y=alu.y, out_carry=alu.c_out, out_zero=(y==0) and out_ovf, and set s2_valid.
- out_ovf rules:
  - add: (A[3]==B[3]) && (y[3]!=A[3])
  - sub: (A[3]!=B[3]) && (y[3]!=A[3])
  - all other ops: 0
- If out_ready && s2_valid && !s1_adv, clear s2_valid. out_valid = s2_valid.
- Stage 2 contents are held stable while out_valid && !out_ready.
- Latency: a command accepted at edge N gives out_valid=1 after edge N+1.
- Accumulator: on s1_adv with s1_wr_acc=1, acc_q <= alu.y.
  - acc_clr is sampled every cycle. When acc_clr and an acc write occur in the same cycle, the clear wins (acc_q=ACC_RST).
  - A command in stage 1 always sees acc updated by all older ops. No hazard exists, because the write happens on the same edge the op leaves stage 1.
- op_count increments on every out_valid && out_ready handshake and wraps from 2^CNT_W-1 to 0.
- Simultaneous accept and advance: the stage-1 register is overwritten with the new command on the same edge its old contents move to stage 2.
- Commands are never dropped or reordered. Results leave in acceptance order.

Decomposition:
- Shared package/include alu_defs.vh holds the opcode localparams (OP_ADD … OP_SHR, 3-bit) used by both alu and this block.
- One sub-module: the existing alu instance (alu_inst).
- Overflow, zero and handshake logic stay inline in this block.

Test Plan:
- Add: reset, then cmd sel=000 a=9 b=8 use_acc=0, out_ready=1 -> 2 cycles later out_y=1, carry=1, zero=0, ovf=1; op_count=1.
- Sub/zero: sel=001 a=3 b=5 -> y=4'hE, carry=1, ovf=0; then sel=001 a=6 b=6 -> y=0, zero=1, carry=0.
- Accumulator chain: acc=0; back-to-back ADD use_acc=1 wr_acc=1 b=5, b=5, b=7 -> y=5, 10, 1 (the last with carry=1), acc_q=1. Repeat with acc_clr asserted alongside the 2nd write -> acc_q=0 after it, 3rd result y=7.
- Backpressure: out_ready=0, issue 3 cmds (shl a=3 b=1; shr a=8 b=3; not a=5) -> in_ready=0 after 2 accepted, out_y=6 held stable. Raise out_ready -> outputs 6, 1, A in order; op_count=3.
- Reset mid-op: accept cmd, assert rst_n=0 before its result -> out_valid=0, acc_q=0, op_count=0 immediately; no result after release.
- Counter wrap (CNT_W=2): 5 handshakes -> op_count=1.
